ccip_host_rd_responder: RTL

- Host/FIU-side model of the CCI-P channel-0 read path: the platform end of the AFU's c0 Tx request / c0 Rx response ports.
- Accepts AFU read requests into a buffer, holds each for a fixed latency, and returns in-order read responses carrying the request's mdata and a deterministic address-derived data pattern.
- Drives c0TxAlmFull backpressure, for use in AFU simulation benches and loopback builds.

---
 rtl/ccip_host_rd_responder_if.sv | 37 +++
 rtl/ccip_host_rd_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ccip_host_rd_responder_if.sv
`timescale 1ns/1ps
// ccip_host_rd_responder_if
// Groups the CCI-P channel-0 read request/response signals between an AFU and
// the host-side read responder.
//   af2cp_c0_valid/addr/mdata : read request from the AFU (single-cycle strobe)
//   cp2af_c0TxAlmFull         : almost-full backpressure toward the AFU
//   cp2af_c0_valid/mdata/data : in-order read responses
//   cp2af_overflow            : sticky flag, a request was dropped
//   cp2af_occupancy           : current request-buffer entry count
// Modports: master = AFU side, slave = host/responder side.
interface ccip_host_rd_responder_if #(
  parameter int DEPTH = 64
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             af2cp_c0_valid;
  logic [41:0]      af2cp_c0_addr;
  logic [15:0]      af2cp_c0_mdata;
  logic             cp2af_c0TxAlmFull;
  logic             cp2af_c0_valid;
  logic [15:0]      cp2af_c0_mdata;
  logic [511:0]     cp2af_c0_data;
  logic             cp2af_overflow;
  logic [OCC_W-1:0] cp2af_occupancy;

  modport master (
    output af2cp_c0_valid, af2cp_c0_addr, af2cp_c0_mdata,
    input  cp2af_c0TxAlmFull, cp2af_c0_valid, cp2af_c0_mdata, cp2af_c0_data,
           cp2af_overflow, cp2af_occupancy
  );

  modport slave (
    input  af2cp_c0_valid, af2cp_c0_addr, af2cp_c0_mdata,
    output cp2af_c0TxAlmFull, cp2af_c0_valid, cp2af_c0_mdata, cp2af_c0_data,
           cp2af_overflow, cp2af_occupancy
  );
endinterface

// File: rtl/ccip_host_rd_responder.sv
`timescale 1ns/1ps
// ccip_host_rd_responder
// Platform-side model of the CCI-P c0 read path. Requests are buffered with a
// timestamp, held for LATENCY cycles and answered strictly in order with the
// echoed mdata and an address-derived pattern in each 64-bit data lane:
//   lane i = {SEED, i[2:0], 3'b000, addr}
// Ports:
//   pClk                  : clock
//   pck_cp2af_softReset_n : async active-low reset (release expected to be
//                           synchronous to pClk already)
//   c0 (slave modport)    : request/response/backpressure bundle
// Optional build macro CCIP_HOST_RSP_JITTER_EN: adds a per-entry 0..3 cycle
// extra delay taken from a 16-bit Galois LFSR that advances on each push.
module ccip_host_rd_responder #(
  parameter int          DEPTH          = 64,
  parameter int          LATENCY        = 16,
  parameter int          ALM_FULL_SLACK = 8,
  parameter logic [15:0] SEED           = 16'hCAFE
) (
  input logic                     pClk,
  input logic                     pck_cp2af_softReset_n,
  ccip_host_rd_responder_if.slave c0
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 64;
  localparam int AW        = $clog2(DEPTH);
  localparam int OCC_W     = AW + 1;

  // Elaboration-time parameter sanity.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 4");
  end
  if (LATENCY < 2 || LATENCY > 1024) begin : g_bad_latency
    $error("LATENCY must be in 2..1024");
  end
  if (ALM_FULL_SLACK >= DEPTH) begin : g_bad_slack
    $error("ALM_FULL_SLACK must be less than DEPTH");
  end
  // Keeps modular age arithmetic free of false eligibility across ts wrap.
  if (DEPTH + LATENCY + 3 >= 32768) begin : g_bad_window
    $error("DEPTH+LATENCY+3 must be below 2^15");
  end

  typedef struct packed {
    logic [41:0] addr;
    logic [15:0] mdata;
  } req_t;

  req_t        req_mem [DEPTH];
  logic [15:0] ts_mem  [DEPTH];

  logic [15:0]      ts;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [OCC_W-1:0] count;
  logic             full, push, pop;
  logic [15:0]      head_age, thresh;
  req_t             head;

  logic                            rsp_valid, alm_full, overflow;
  logic [15:0]                     rsp_mdata;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_data, rsp_data;

  assign head = req_mem[rd_ptr];
  assign full = (count == OCC_W'(DEPTH));
  // Full test uses the pre-pop count: a pop in the same cycle does not save it.
  assign push = c0.af2cp_c0_valid && !full;

  // Response is registered, so judge the head by the age it will have when
  // its response is on the bus (one cycle from now).
  assign head_age = ts + 16'd1 - ts_mem[rd_ptr];
  assign pop      = (count != '0) && (head_age >= thresh);

`ifdef CCIP_HOST_RSP_JITTER_EN
  logic [15:0] lfsr;
  logic [1:0]  xtra_mem [DEPTH];

  assign thresh = 16'(LATENCY) + {14'd0, xtra_mem[rd_ptr]};

  always_ff @(posedge pClk) begin
    if (push) xtra_mem[wr_ptr] <= lfsr[1:0];
  end

  // Galois form, taps 16,14,13,11, shifting right.
  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) lfsr <= 16'hACE1;
    else if (push)              lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
`else
  assign thresh = 16'(LATENCY);
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [2:0] LANE_IDX = 3'(i);
    assign lane_data[i] = {SEED, LANE_IDX, 3'b000, head.addr};
  end

  // Storage carries no reset; pointers and count define what is live.
  always_ff @(posedge pClk) begin
    if (push) begin
      req_mem[wr_ptr] <= '{addr: c0.af2cp_c0_addr, mdata: c0.af2cp_c0_mdata};
      ts_mem[wr_ptr]  <= ts;
    end
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      ts        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      alm_full  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_mdata <= '0;
      rsp_data  <= '0;
    end else begin
      ts        <= ts + 16'd1;
      count     <= count + OCC_W'(push) - OCC_W'(pop);
      // Lags occupancy by one cycle by design.
      alm_full  <= (count >= OCC_W'(DEPTH - ALM_FULL_SLACK));
      rsp_valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (c0.af2cp_c0_valid && full) overflow <= 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rsp_mdata <= head.mdata;
        rsp_data  <= lane_data;
      end
    end
  end

  assign c0.cp2af_c0TxAlmFull = alm_full;
  assign c0.cp2af_c0_valid    = rsp_valid;
  assign c0.cp2af_c0_mdata    = rsp_mdata;
  assign c0.cp2af_c0_data     = rsp_data;
  assign c0.cp2af_overflow    = overflow;
  assign c0.cp2af_occupancy   = count;
endmodule
